// File: rtl/mem_stage.sv
// RV32I MEM stage: issues dmem accesses, aligns store lanes, extends load data, registers MEM/WB.
// Define MEM_STAGE_PERF_EN to build the load/store/stall performance counters.
module mem_stage #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_mem_re,
  input  logic              ex_mem_we,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_regf_we,
  input  logic [XLEN-1:0]   ex_res,
  output logic              stall_out,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_resp,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_regf_we,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_misalign,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_stall_cyc
);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        a_q, a_d;
  logic [4:0]        rd_q, rd_d;
  logic              rwe_q, rwe_d;
  logic              load_q, load_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic              wb_rwe_q, wb_rwe_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              wb_mis_q, wb_mis_d;
  logic              stall_c;
  logic [3:0]        rmask_c, wmask_c;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  logic [1:0]      ex_a;
  logic            ex_is_mem, ex_mis;
  logic [XLEN-1:0] rd_shift, load_val;

  assign ex_a      = ex_addr[1:0];
  assign ex_is_mem = ex_mem_re | ex_mem_we;
  assign ex_mis    = ex_is_mem & is_misaligned(ex_funct3, ex_a);
  assign rd_shift  = dmem_rdata >> {a_q, 3'b000};

  // Load extension from the latched width/sign code
  always_comb begin
    load_val = rd_shift;
    case (f3_q)
      3'b000:  load_val = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_val = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  // Next-state, request and writeback logic
  always_comb begin
    state_d    = state_q;
    f3_d       = f3_q;
    a_d        = a_q;
    rd_d       = rd_q;
    rwe_d      = rwe_q;
    load_d     = load_q;
    res_d      = res_q;
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_rwe_d   = wb_rwe_q;
    wb_data_d  = wb_data_q;
    wb_mis_d   = wb_mis_q;
    stall_c    = 1'b0;
    rmask_c    = 4'b0000;
    wmask_c    = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (!ex_valid) begin
          wb_valid_d = 1'b0;
        end else if (ex_is_mem && !ex_mis) begin
          rmask_c    = ex_mem_re ? lane_mask(ex_funct3, ex_a) : 4'b0000;
          wmask_c    = (ex_mem_we && !ex_mem_re) ? lane_mask(ex_funct3, ex_a) : 4'b0000;
          stall_c    = 1'b1;
          f3_d       = ex_funct3;
          a_d        = ex_a;
          rd_d       = ex_rd;
          rwe_d      = ex_regf_we;
          load_d     = ex_mem_re;
          res_d      = ex_res;
          wb_valid_d = 1'b0;
          state_d    = S_WAIT;
        end else begin
          wb_valid_d = 1'b1;
          wb_rd_d    = ex_rd;
          wb_rwe_d   = ex_regf_we & ~ex_mis;
          wb_data_d  = ex_res;
          wb_mis_d   = ex_mis;
        end
      end
      S_WAIT: begin
        if (dmem_resp) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_rwe_d   = rwe_q;
          wb_data_d  = load_q ? load_val : res_q;
          wb_mis_d   = 1'b0;
          state_d    = S_IDLE;
        end else begin
          stall_c    = 1'b1;
          wb_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      f3_q       <= 3'b000;
      a_q        <= 2'b00;
      rd_q       <= 5'd0;
      rwe_q      <= 1'b0;
      load_q     <= 1'b0;
      res_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_rwe_q   <= 1'b0;
      wb_data_q  <= '0;
      wb_mis_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      f3_q       <= f3_d;
      a_q        <= a_d;
      rd_q       <= rd_d;
      rwe_q      <= rwe_d;
      load_q     <= load_d;
      res_q      <= res_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_rwe_q   <= wb_rwe_d;
      wb_data_q  <= wb_data_d;
      wb_mis_q   <= wb_mis_d;
    end
  end

  assign stall_out   = stall_c;
  assign dmem_addr   = {ex_addr[ADDR_W-1:2], 2'b00};
  assign dmem_rmask  = rmask_c;
  assign dmem_wmask  = wmask_c;
  assign dmem_wdata  = ex_wdata << {ex_a, 3'b000};
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regf_we  = wb_rwe_q;
  assign wb_data     = wb_data_q;
  assign wb_misalign = wb_mis_q;

`ifdef MEM_STAGE_PERF_EN
  logic [31:0] loads_q, stores_q, stall_cyc_q;
  logic        resp_done;

  assign resp_done = (state_q == S_WAIT) && dmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q     <= 32'd0;
      stores_q    <= 32'd0;
      stall_cyc_q <= 32'd0;
    end else begin
      if (resp_done && load_q)  loads_q     <= loads_q + 32'd1;
      if (resp_done && !load_q) stores_q    <= stores_q + 32'd1;
      if (stall_c)              stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign perf_loads     = loads_q;
  assign perf_stores    = stores_q;
  assign perf_stall_cyc = stall_cyc_q;
`else
  assign perf_loads     = 32'd0;
  assign perf_stores    = 32'd0;
  assign perf_stall_cyc = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, random ops vs. a byte-level reference model, reset corners.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_re, ex_mem_we, ex_regf_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata, ex_res;
  logic [4:0]  ex_rd;
  logic        stall_out;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp;
  logic        wb_valid, wb_regf_we, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] perf_loads, perf_stores, perf_stall_cyc;

  int n_checks = 0;
  int n_errors = 0;
  int exp_loads = 0, exp_stores = 0, exp_stall = 0;

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rd(ex_rd), .ex_regf_we(ex_regf_we), .ex_res(ex_res),
    .stall_out(stall_out), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_regf_we(wb_regf_we), .wb_data(wb_data), .wb_misalign(wb_misalign),
    .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall_cyc(perf_stall_cyc)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        valid, re, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        rwe;
    logic [31:0] res;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] e_data;
    logic [3:0]  e_rmask, e_wmask;
    logic [31:0] e_dwdata;
    logic        e_rwe, e_mis;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, re, we, input logic [2:0] f3,
                              input logic [31:0] addr, wdata, input logic [4:0] rd,
                              input logic rwe, input logic [31:0] res, input int lat,
                              input logic [31:0] rdata, e_data, input logic [3:0] e_rmask,
                              e_wmask, input logic [31:0] e_dwdata, input logic e_rwe, e_mis);
    vec_t v;
    v.valid = valid; v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.rwe = rwe; v.res = res; v.lat = lat; v.rdata = rdata;
    v.e_data = e_data; v.e_rmask = e_rmask; v.e_wmask = e_wmask; v.e_dwdata = e_dwdata;
    v.e_rwe = e_rwe; v.e_mis = e_mis;
    return v;
  endfunction

  // Reference: access size in bytes, byte-lane extraction and numeric sign extension
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     sz, a;
    longint val, m;
    logic   mem;
    r   = v;
    sz  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    a   = int'(v.addr % 4);
    mem = v.re || v.we;
    r.e_mis    = v.valid && mem && ((a % sz) != 0);
    r.e_rmask  = 4'd0;
    r.e_wmask  = 4'd0;
    r.e_dwdata = 32'({32'd0, v.wdata} * (64'd1 << (8 * a)));
    r.e_rwe    = v.rwe && !r.e_mis;
    r.e_data   = v.res;
    if (v.valid && mem && !r.e_mis) begin
      m = ((64'd1 << sz) - 1) * (64'd1 << a);
      if (v.re) r.e_rmask = 4'(m);
      else      r.e_wmask = 4'(m);
      if (v.re) begin
        val = longint'({32'd0, v.rdata}) / (64'sd1 << (8 * a));
        if (sz < 4) begin
          val = val % (64'sd1 << (8 * sz));
          if (!v.f3[2] && val >= (64'sd1 << (8 * sz - 1))) val = val - (64'sd1 << (8 * sz));
        end
        r.e_data = 32'(val);
      end
    end
    return r;
  endfunction

  task automatic do_op(input vec_t v, input logic resp_in_issue);
    logic issue, last;
    ex_valid = v.valid; ex_mem_re = v.re; ex_mem_we = v.we; ex_funct3 = v.f3;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd; ex_regf_we = v.rwe; ex_res = v.res;
    dmem_resp = resp_in_issue;
    dmem_rdata = $urandom;
    #1;
    issue = v.valid && (v.re || v.we) && !v.e_mis;
    chk("stall_issue", 32'(stall_out), 32'(issue));
    chk("rmask", 32'(dmem_rmask), 32'(v.e_rmask));
    chk("wmask", 32'(dmem_wmask), 32'(v.e_wmask));
    if (issue) chk("dmem_addr", dmem_addr, v.addr & 32'hFFFF_FFFC);
    if (issue && v.we) chk("dmem_wdata", dmem_wdata, v.e_dwdata);
    step();
    if (issue) begin
      for (int k = 0; k < v.lat; k++) begin
        last = (k == v.lat - 1);
        dmem_resp  = last;
        dmem_rdata = last ? v.rdata : $urandom;
        #1;
        chk("stall_wait", 32'(stall_out), 32'(!last));
        chk("wait_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
        chk("wait_wb_valid", 32'(wb_valid), 32'd0);
        step();
      end
      exp_stall += v.lat;
      if (v.re) exp_loads++;
      else      exp_stores++;
    end
    ex_valid  = 1'b0;
    dmem_resp = 1'b0;
    chk("wb_valid", 32'(wb_valid), 32'(v.valid));
    if (v.valid) begin
      chk("wb_rd", 32'(wb_rd), 32'(v.rd));
      chk("wb_regf_we", 32'(wb_regf_we), 32'(v.e_rwe));
      chk("wb_data", wb_data, v.e_data);
      chk("wb_misalign", 32'(wb_misalign), 32'(v.e_mis));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_funct3 = 3'd0;
    ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0; ex_regf_we = 1'b0; ex_res = 32'd0;
    dmem_resp = 1'b0; dmem_rdata = 32'd0;
    step();
    step();
    rst = 1'b0;
    exp_loads = 0; exp_stores = 0; exp_stall = 0;
  endtask

  task automatic chk_perf(input string nm);
`ifdef MEM_STAGE_PERF_EN
    chk({nm, "_loads"}, perf_loads, 32'(exp_loads));
    chk({nm, "_stores"}, perf_stores, 32'(exp_stores));
    chk({nm, "_stall"}, perf_stall_cyc, 32'(exp_stall));
`else
    chk({nm, "_off"}, perf_loads | perf_stores | perf_stall_cyc, 32'd0);
`endif
  endtask

  vec_t tbl[15];
  vec_t rv;
  logic [2:0] ld_f3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    tbl[0]  = mk(1,0,0,3'b000,32'h0,   32'h0,       5'd5, 1,32'h1234,0,32'h0,        32'h1234,    4'b0000,4'b0000,32'h0,       1,0);
    tbl[1]  = mk(1,1,0,3'b000,32'h1003,32'h0,       5'd6, 1,32'hAAAA,2,32'h80123456, 32'hFFFFFF80,4'b1000,4'b0000,32'h0,       1,0);
    tbl[2]  = mk(1,1,0,3'b100,32'h1003,32'h0,       5'd6, 1,32'hAAAA,2,32'h80123456, 32'h00000080,4'b1000,4'b0000,32'h0,       1,0);
    tbl[3]  = mk(1,0,1,3'b001,32'h2002,32'h0000BEEF,5'd0, 0,32'h2002,1,32'h0,        32'h2002,    4'b0000,4'b1100,32'hBEEF0000,0,0);
    tbl[4]  = mk(1,1,0,3'b010,32'h3001,32'h0,       5'd7, 1,32'h55,  0,32'h0,        32'h55,      4'b0000,4'b0000,32'h0,       0,1);
    tbl[5]  = mk(1,1,0,3'b001,32'h1002,32'h0,       5'd8, 1,32'h0,   1,32'h80017777, 32'hFFFF8001,4'b1100,4'b0000,32'h0,       1,0);
    tbl[6]  = mk(1,1,0,3'b101,32'h1000,32'h0,       5'd9, 1,32'h0,   2,32'h1234ABCD, 32'h0000ABCD,4'b0011,4'b0000,32'h0,       1,0);
    tbl[7]  = mk(1,1,0,3'b010,32'h1004,32'h0,       5'd10,1,32'h0,   3,32'hDEADBEEF, 32'hDEADBEEF,4'b1111,4'b0000,32'h0,       1,0);
    tbl[8]  = mk(1,0,1,3'b000,32'h5001,32'h000000A5,5'd0, 0,32'h5001,1,32'h0,        32'h5001,    4'b0000,4'b0010,32'h0000A500,0,0);
    tbl[9]  = mk(1,0,1,3'b010,32'h6000,32'hCAFEF00D,5'd0, 0,32'h6000,2,32'h0,        32'h6000,    4'b0000,4'b1111,32'hCAFEF00D,0,0);
    tbl[10] = mk(1,0,1,3'b001,32'h7003,32'h1111,    5'd0, 0,32'h77,  0,32'h0,        32'h77,      4'b0000,4'b0000,32'h0,       0,1);
    tbl[11] = mk(0,1,0,3'b010,32'h1000,32'h0,       5'd3, 1,32'h0,   0,32'h0,        32'h0,       4'b0000,4'b0000,32'h0,       0,0);
    tbl[12] = mk(1,1,0,3'b000,32'h1001,32'h0,       5'd11,1,32'h0,   1,32'h00007F00, 32'h0000007F,4'b0010,4'b0000,32'h0,       1,0);
    tbl[13] = mk(1,1,0,3'b101,32'h1001,32'h0,       5'd12,1,32'h99,  0,32'h0,        32'h99,      4'b0000,4'b0000,32'h0,       0,1);
    tbl[14] = mk(1,0,1,3'b000,32'h5003,32'h000000FF,5'd0, 0,32'h5003,1,32'h0,        32'h5003,    4'b0000,4'b1000,32'hFF000000,0,0);

    do_reset();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_fields", {wb_data[26:0], wb_rd}, 32'd0);
    chk("rst_wb_flags", 32'({wb_regf_we, wb_misalign}), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    chk_perf("rst_perf");

    for (int i = 0; i < 15; i++) do_op(tbl[i], 1'b0);

    // Reset while waiting; a late response must not produce a writeback
    ex_valid = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h4000; ex_rd = 5'd4; ex_regf_we = 1'b1; ex_res = 32'h0;
    step();
    rst = 1'b1; ex_valid = 1'b0;
    step();
    rst = 1'b0;
    exp_loads = 0; exp_stores = 0; exp_stall = 0;
    dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    #1;
    chk("rstwait_stall", 32'(stall_out), 32'd0);
    chk("rstwait_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    step();
    dmem_resp = 1'b0;
    chk("rstwait_wb_valid", 32'(wb_valid), 32'd0);
    chk_perf("rstwait_perf");
    do_op(tbl[0], 1'b0);

    for (int i = 0; i < 250; i++) begin
      int kind;
      kind = int'($urandom % 4);
      rv = mk(kind != 3, 0, 0, 3'b000, $urandom, $urandom, 5'($urandom), 1'($urandom),
              $urandom, 1 + int'($urandom % 3), $urandom, 0, 0, 0, 0, 0, 0);
      if (kind == 1) begin rv.re = 1'b1; rv.f3 = ld_f3[$urandom % 5]; end
      if (kind == 2) begin rv.we = 1'b1; rv.f3 = 3'($urandom % 3); end
      if (kind == 3) begin rv.re = 1'($urandom); rv.f3 = 3'b000; end
      rv = model(rv);
      do_op(rv, 1'($urandom));
    end
    chk_perf("rand_perf");

    do_reset();
    for (int i = 0; i < 3; i++)
      do_op(mk(1,1,0,3'b010,32'h8000 + 32'(4*i),32'h0,5'd1,1,32'h0,3,32'h11110000 + 32'(i),
               32'h11110000 + 32'(i),4'b1111,4'b0000,32'h0,1,0), 1'b0);
`ifdef MEM_STAGE_PERF_EN
    chk("perf3_loads", perf_loads, 32'd3);
    chk("perf3_stall", perf_stall_cyc, 32'd9);
    chk("perf3_stores", perf_stores, 32'd0);
`else
    chk("perf3_off", perf_loads | perf_stores | perf_stall_cyc, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
